bus_transfer_unit: RTL and testbench

- Destination end of the 4-line register bus: sequences one register-to-register (or external-to-register) transfer per request.
- Source register or external data is driven onto a registered bus latch; the decoded destination register then loads from the bus.
- Holds the four 4-bit bus registers A-D, so the source-side mux and the destination-side load decoder live in one clocked block.

---
 rtl/bus_transfer_unit_pkg.sv | 21 ++
 rtl/bus_transfer_unit_decoder.sv | 22 ++
 rtl/bus_transfer_unit_mux4.sv | 29 ++
 rtl/bus_transfer_unit.sv | 135 +++++++++++++
 tb/tb_bus_transfer_unit.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/bus_transfer_unit_pkg.sv
// Shared types and constants for the register-bus transfer unit:
// FSM state encoding, register select codes and default widths.
package bus_transfer_unit_pkg;

   localparam int WIDTH_DEF = 4;
   localparam int NUM_REGS  = 4;
   localparam int SEL_W     = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      DRIVE = 2'b01,
      LOAD  = 2'b10
   } state_t;

   // Register select codes: bit1 = select_x, bit0 = select_y.
   localparam logic [SEL_W-1:0] SEL_A = 2'b00;
   localparam logic [SEL_W-1:0] SEL_B = 2'b01;
   localparam logic [SEL_W-1:0] SEL_C = 2'b10;
   localparam logic [SEL_W-1:0] SEL_D = 2'b11;

endpackage

// File: rtl/bus_transfer_unit_decoder.sv
// Gate-level 2-to-4 destination decoder with enable; yields one-hot register
// load strobes, all low when the enable is low.
module bus_dest_decoder
   import bus_transfer_unit_pkg::*;
(
   input  logic             en,
   input  logic [SEL_W-1:0] sel,
   output logic [3:0]       load_en
);

   logic sel_x_n;
   logic sel_y_n;

   assign sel_x_n = ~sel[1];
   assign sel_y_n = ~sel[0];

   assign load_en[0] = en & sel_x_n & sel_y_n;
   assign load_en[1] = en & sel_x_n & sel[0];
   assign load_en[2] = en & sel[1]  & sel_y_n;
   assign load_en[3] = en & sel[1]  & sel[0];

endmodule

// File: rtl/bus_transfer_unit_mux4.sv
// Gate-level 4x1 single-bit multiplexer; one instance per bus bit forms the
// source-side register mux.
module bus_transfer_unit_mux4 (
   input  logic       d0,
   input  logic       d1,
   input  logic       d2,
   input  logic       d3,
   input  logic [1:0] sel,
   output logic       y
);

   logic sel_x_n;
   logic sel_y_n;
   logic term0;
   logic term1;
   logic term2;
   logic term3;

   assign sel_x_n = ~sel[1];
   assign sel_y_n = ~sel[0];

   assign term0 = sel_x_n & sel_y_n & d0;
   assign term1 = sel_x_n & sel[0]  & d1;
   assign term2 = sel[1]  & sel_y_n & d2;
   assign term3 = sel[1]  & sel[0]  & d3;

   assign y = term0 | term1 | term2 | term3;

endmodule

// File: rtl/bus_transfer_unit.sv
// Destination end of the 4-line register bus: holds registers A-D and moves one
// value (register or external) through the bus latch into a register per request.
module bus_transfer_unit
   import bus_transfer_unit_pkg::*;
#(
   parameter int               WIDTH     = WIDTH_DEF,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       src_sel,
   input  logic [1:0]       dst_sel,
   input  logic             ext_en,
   input  logic [WIDTH-1:0] ext_data,
   output logic [WIDTH-1:0] bus_out,
   output logic             done,
   output logic [WIDTH-1:0] reg_a,
   output logic [WIDTH-1:0] reg_b,
   output logic [WIDTH-1:0] reg_c,
   output logic [WIDTH-1:0] reg_d,
   output logic [1:0]       state_dbg
);

   // Handshake: a request transfers on a rising edge where req_valid and
   // req_ready are both 1; req_ready is high only in IDLE, and the requester
   // holds req_valid and its fields stable until that edge.

   state_t           state_q;
   state_t           state_d;
   logic             accept;
   logic             load_active;

   logic [1:0]       src_q;
   logic [1:0]       dst_q;
   logic             ext_en_q;
   logic [WIDTH-1:0] ext_data_q;

   logic [WIDTH-1:0] bus_q;
   logic             done_q;
   logic [WIDTH-1:0] regs_q [NUM_REGS];

   logic [WIDTH-1:0] src_bus;
   logic [3:0]       load_en;

   // Source mux, one gate-level slice per bus bit.
   for (genvar b = 0; b < WIDTH; b++) begin : g_src_mux
      bus_transfer_unit_mux4 u_mux (
         .d0  (regs_q[0][b]),
         .d1  (regs_q[1][b]),
         .d2  (regs_q[2][b]),
         .d3  (regs_q[3][b]),
         .sel (src_q),
         .y   (src_bus[b])
      );
   end

   assign load_active = (state_q == LOAD);

   bus_dest_decoder u_dst_dec (
      .en      (load_active),
      .sel     (dst_q),
      .load_en (load_en)
   );

   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      accept    = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            accept    = req_valid;
            if (req_valid) begin
               state_d = DRIVE;
            end
         end
         DRIVE: begin
            state_d = LOAD;
         end
         LOAD: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         src_q      <= '0;
         dst_q      <= '0;
         ext_en_q   <= 1'b0;
         ext_data_q <= '0;
         bus_q      <= RESET_VAL;
         done_q     <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= RESET_VAL;
         end
      end else begin
         state_q <= state_d;
         done_q  <= load_active;

         if (accept) begin
            src_q      <= src_sel;
            dst_q      <= dst_sel;
            ext_en_q   <= ext_en;
            ext_data_q <= ext_data;
         end

         if (state_q == DRIVE) begin
            bus_q <= ext_en_q ? ext_data_q : src_bus;
         end

         // Destination loads from the latched bus, not from the source mux.
         for (int i = 0; i < NUM_REGS; i++) begin
            if (load_en[i]) begin
               regs_q[i] <= bus_q;
            end
         end
      end
   end

   assign bus_out   = bus_q;
   assign done      = done_q;
   assign reg_a     = regs_q[0];
   assign reg_b     = regs_q[1];
   assign reg_c     = regs_q[2];
   assign reg_d     = regs_q[3];
   assign state_dbg = state_q;

endmodule

// File: tb/tb_bus_transfer_unit.sv
// Directed and randomized bench for bus_transfer_unit against a transfer-level
// model of the four registers and the bus latch.
module tb_bus_transfer_unit;

   localparam int WIDTH = 4;

   logic             clk;
   logic             rst_n;
   logic             req_valid;
   logic             req_ready;
   logic [1:0]       src_sel;
   logic [1:0]       dst_sel;
   logic             ext_en;
   logic [WIDTH-1:0] ext_data;
   logic [WIDTH-1:0] bus_out;
   logic             done;
   logic [WIDTH-1:0] reg_a;
   logic [WIDTH-1:0] reg_b;
   logic [WIDTH-1:0] reg_c;
   logic [WIDTH-1:0] reg_d;
   logic [1:0]       state_dbg;

   int checks = 0;
   int errors = 0;
   int cycle  = 0;

   logic [WIDTH-1:0] model_reg [4];
   logic [WIDTH-1:0] model_bus;

   bus_transfer_unit #(.WIDTH(WIDTH), .RESET_VAL('0)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .src_sel   (src_sel),
      .dst_sel   (dst_sel),
      .ext_en    (ext_en),
      .ext_data  (ext_data),
      .bus_out   (bus_out),
      .done      (done),
      .reg_a     (reg_a),
      .reg_b     (reg_b),
      .reg_c     (reg_c),
      .reg_d     (reg_d),
      .state_dbg (state_dbg)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cycle++;

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, observed running expected finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_regs(input string tag);
      check({tag, " reg_a"}, 32'(reg_a), 32'(model_reg[0]));
      check({tag, " reg_b"}, 32'(reg_b), 32'(model_reg[1]));
      check({tag, " reg_c"}, 32'(reg_c), 32'(model_reg[2]));
      check({tag, " reg_d"}, 32'(reg_d), 32'(model_reg[3]));
   endtask

   task automatic next_negedge();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) model_reg[i] = '0;
      model_bus = '0;
   endtask

   // Driver: called at a negedge with the DUT idle. Runs one full transfer and
   // returns at the negedge after the destination write, where done is high.
   // With hold=1 the next request is presented right after acceptance.
   task automatic transfer(input string tag,
                           input logic [1:0] src, input logic [1:0] dst,
                           input logic ext, input logic [WIDTH-1:0] data,
                           input bit hold,
                           input logic [1:0] nsrc, input logic [1:0] ndst,
                           input logic next, input logic [WIDTH-1:0] ndata,
                           output int done_cycle);
      logic [WIDTH-1:0] value;
      req_valid = 1'b1;
      src_sel   = src;
      dst_sel   = dst;
      ext_en    = ext;
      ext_data  = data;
      check({tag, " ready_idle"}, 32'(req_ready), 32'd1);
      value = ext ? data : model_reg[src];
      next_negedge();                               // accepted at E0
      if (hold) begin
         src_sel  = nsrc;
         dst_sel  = ndst;
         ext_en   = next;
         ext_data = ndata;
      end else begin
         req_valid = 1'b0;
         src_sel   = 2'($urandom_range(0, 3));
         dst_sel   = 2'($urandom_range(0, 3));
         ext_en    = 1'($urandom_range(0, 1));
         ext_data  = WIDTH'($urandom_range(0, 15));
      end
      check({tag, " ready_drive"}, 32'(req_ready), 32'd0);
      check({tag, " done_drive"}, 32'(done), 32'd0);
      check({tag, " bus_before"}, 32'(bus_out), 32'(model_bus));
      next_negedge();                               // E1: bus latched
      model_bus = value;
      check({tag, " bus_after_e1"}, 32'(bus_out), 32'(model_bus));
      check({tag, " ready_load"}, 32'(req_ready), 32'd0);
      check({tag, " done_load"}, 32'(done), 32'd0);
      check_regs({tag, " pre_write"});
      next_negedge();                               // E2: destination write
      model_reg[dst] = value;
      check({tag, " done_pulse"}, 32'(done), 32'd1);
      check({tag, " ready_after"}, 32'(req_ready), 32'd1);
      check({tag, " bus_hold"}, 32'(bus_out), 32'(model_bus));
      check_regs({tag, " post_write"});
      done_cycle = cycle;
   endtask

   task automatic idle_cycles(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         next_negedge();
         check({tag, " idle_done"}, 32'(done), 32'd0);
         check({tag, " idle_ready"}, 32'(req_ready), 32'd1);
         check({tag, " idle_bus"}, 32'(bus_out), 32'(model_bus));
         check_regs({tag, " idle"});
      end
   endtask

   // Stimulus
   initial begin
      int dc1;
      int dc2;
      logic [1:0]       c_src, c_dst, n_src, n_dst;
      logic             c_ext, n_ext;
      logic [WIDTH-1:0] c_data, n_data;
      bit               hold;

      rst_n     = 1'b0;
      req_valid = 1'b0;
      src_sel   = '0;
      dst_sel   = '0;
      ext_en    = 1'b0;
      ext_data  = '0;
      model_reset();

      // Reset held for two cycles
      repeat (2) next_negedge();
      rst_n = 1'b1;
      check("reset bus", 32'(bus_out), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset ready", 32'(req_ready), 32'd1);
      check("reset state", 32'(state_dbg), 32'(bus_transfer_unit_pkg::IDLE));
      check_regs("reset");
      idle_cycles("post_reset", 1);

      // External load 1010 into B
      transfer("ext_b", 2'b00, 2'b01, 1'b1, 4'b1010, 1'b0, '0, '0, 1'b0, '0, dc1);
      idle_cycles("ext_b", 1);

      // Register copy A -> D after preloading A = 0001
      transfer("pre_a", 2'b00, 2'b00, 1'b1, 4'b0001, 1'b0, '0, '0, 1'b0, '0, dc1);
      idle_cycles("pre_a", 1);
      transfer("copy_ad", 2'b00, 2'b11, 1'b0, 4'b1111, 1'b0, '0, '0, 1'b0, '0, dc1);
      idle_cycles("copy_ad", 2);

      // Back-to-back: second request presented during DRIVE/LOAD
      transfer("b2b_1", 2'b00, 2'b10, 1'b1, 4'b0110, 1'b1,
               2'b10, 2'b01, 1'b0, 4'b1001, dc1);
      transfer("b2b_2", 2'b10, 2'b01, 1'b0, 4'b1001, 1'b0, '0, '0, 1'b0, '0, dc2);
      check("b2b spacing", 32'(dc2 - dc1), 32'd3);
      idle_cycles("b2b", 1);

      // Self-copy of C = 0100
      transfer("pre_c", 2'b00, 2'b10, 1'b1, 4'b0100, 1'b0, '0, '0, 1'b0, '0, dc1);
      idle_cycles("pre_c", 1);
      transfer("self_c", 2'b10, 2'b10, 1'b0, 4'b0000, 1'b0, '0, '0, 1'b0, '0, dc1);
      idle_cycles("self_c", 2);

      // Reset while in DRIVE for an external load of 1111 into D
      req_valid = 1'b1;
      src_sel   = 2'b00;
      dst_sel   = 2'b11;
      ext_en    = 1'b1;
      ext_data  = 4'b1111;
      next_negedge();
      check("midrst in_drive", 32'(state_dbg), 32'(bus_transfer_unit_pkg::DRIVE));
      req_valid = 1'b0;
      rst_n     = 1'b0;
      model_reset();
      next_negedge();
      rst_n = 1'b1;
      check("midrst state", 32'(state_dbg), 32'(bus_transfer_unit_pkg::IDLE));
      check("midrst done", 32'(done), 32'd0);
      check("midrst bus", 32'(bus_out), 32'd0);
      check_regs("midrst");
      idle_cycles("midrst", 3);

      // Randomized transfers with optional back-to-back holding
      c_src  = 2'($urandom_range(0, 3));
      c_dst  = 2'($urandom_range(0, 3));
      c_ext  = 1'($urandom_range(0, 1));
      c_data = WIDTH'($urandom_range(0, 15));
      for (int i = 0; i < 40; i++) begin
         n_src  = 2'($urandom_range(0, 3));
         n_dst  = 2'($urandom_range(0, 3));
         n_ext  = 1'($urandom_range(0, 1));
         n_data = WIDTH'($urandom_range(0, 15));
         hold   = 1'($urandom_range(0, 1));
         transfer("rand", c_src, c_dst, c_ext, c_data, hold,
                  n_src, n_dst, n_ext, n_data, dc1);
         if (!hold) idle_cycles("rand", $urandom_range(1, 3));
         c_src  = n_src;
         c_dst  = n_dst;
         c_ext  = n_ext;
         c_data = n_data;
      end
      idle_cycles("final", 1);

      // final report
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
